// File: rtl/demux_1_4_8bit_reg.sv
// Registered 1-to-4 demultiplexer: one valid/ready input stream steered by sel_i
// into four independent one-entry holding registers, plus an accepted-word counter.
module demux_1_4_8bit_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [1:0]        sel_i,
  output logic [3:0]        out_valid_o,
  input  logic [3:0]        out_ready_i,
  output logic [DATA_W-1:0] out0_data_o,
  output logic [DATA_W-1:0] out1_data_o,
  output logic [DATA_W-1:0] out2_data_o,
  output logic [DATA_W-1:0] out3_data_o,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int unsigned N_OUT = 4;

  logic [N_OUT-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [N_OUT];
  logic [CNT_W-1:0]  r_cnt;

  logic [N_OUT-1:0]  w_free;
  logic              w_push;

  // A slot is free when empty or being drained this edge; only the selected slot gates the input.
  assign w_free     = ~r_valid | out_ready_i;
  assign in_ready_o = w_free[sel_i];
  assign w_push     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int k = 0; k < int'(N_OUT); k++) begin
        r_data[k] <= '0;
      end
    end else begin
      // Fill takes priority over drain so a same-edge drain+fill keeps the slot valid.
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (w_push && (sel_i == 2'(k))) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data_i;
        end else if (out_ready_i[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_push) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out0_data_o = r_data[0];
  assign out1_data_o = r_data[1];
  assign out2_data_o = r_data[2];
  assign out3_data_o = r_data[3];
  assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_demux_1_4_8bit_reg.sv
// Directed self-checking bench for demux_1_4_8bit_reg.
module tb_demux_1_4_8bit_reg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [1:0]        sel_i;
  logic [3:0]        out_valid_o;
  logic [3:0]        out_ready_i;
  logic [DATA_W-1:0] out0_data_o, out1_data_o, out2_data_o, out3_data_o;
  logic [CNT_W-1:0]  cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  demux_1_4_8bit_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .sel_i       (sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out0_data_o (out0_data_o),
    .out1_data_o (out1_data_o),
    .out2_data_o (out2_data_o),
    .out3_data_o (out3_data_o),
    .cnt_o       (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] dout(input int k);
    case (k)
      0:       return out0_data_o;
      1:       return out1_data_o;
      2:       return out2_data_o;
      default: return out3_data_o;
    endcase
  endfunction

  initial begin
    rstn_i      = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'h55;
    sel_i       = 2'd0;
    out_ready_i = 4'b0000;

    // Reset with a valid input pending
    tick();
    tick();
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_cnt", 32'(cnt_o), 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k), 32'(dout(k)), 32'h0);
    rstn_i     = 1'b1;
    in_valid_i = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready_o), 32'h1);

    // Routing to each output
    out_ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      sel_i      = 2'(i);
      in_data_i  = 8'(8'hA0 + i);
      #1;
      chk($sformatf("route_rdy%0d", i), 32'(in_ready_o), 32'h1);
      tick();
      chk($sformatf("route_valid%0d", i), 32'(out_valid_o), 32'(4'b0001 << i));
      chk($sformatf("route_data%0d", i), 32'(dout(i)), 32'(8'hA0 + i));
    end
    in_valid_i = 1'b0;
    tick();
    chk("route_drained", 32'(out_valid_o), 32'h0);
    chk("route_cnt", 32'(cnt_o), 32'd4);

    // Backpressure isolation on output 0
    out_ready_i = 4'b1110;
    in_valid_i  = 1'b1;
    sel_i       = 2'd0;
    in_data_i   = 8'h11;
    tick();
    chk("bp_valid_a", 32'(out_valid_o), 32'b0001);
    chk("bp_data0_a", 32'(out0_data_o), 32'h11);
    sel_i = 2'd1; in_data_i = 8'h33;
    #1; chk("bp_rdy1", 32'(in_ready_o), 32'h1);
    tick();
    chk("bp_valid_b", 32'(out_valid_o), 32'b0011);
    chk("bp_data1", 32'(out1_data_o), 32'h33);
    sel_i = 2'd2; in_data_i = 8'h44;
    #1; chk("bp_rdy2", 32'(in_ready_o), 32'h1);
    tick();
    chk("bp_valid_c", 32'(out_valid_o), 32'b0101);
    chk("bp_data2", 32'(out2_data_o), 32'h44);
    sel_i = 2'd3; in_data_i = 8'h55;
    #1; chk("bp_rdy3", 32'(in_ready_o), 32'h1);
    tick();
    chk("bp_valid_d", 32'(out_valid_o), 32'b1001);
    chk("bp_data3", 32'(out3_data_o), 32'h55);
    sel_i = 2'd0; in_data_i = 8'h22;
    #1; chk("bp_stall_rdy", 32'(in_ready_o), 32'h0);
    tick();
    chk("bp_stall_valid", 32'(out_valid_o), 32'b0001);
    chk("bp_stall_data0", 32'(out0_data_o), 32'h11);
    chk("bp_stall_cnt", 32'(cnt_o), 32'd8);
    out_ready_i = 4'b1111;
    #1; chk("bp_release_rdy", 32'(in_ready_o), 32'h1);
    tick();
    chk("bp_fill_valid", 32'(out_valid_o), 32'b0001);
    chk("bp_fill_data0", 32'(out0_data_o), 32'h22);
    chk("bp_fill_cnt", 32'(cnt_o), 32'd9);
    in_valid_i = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid_o), 32'h0);

    // Full throughput on output 2
    in_valid_i = 1'b1;
    sel_i      = 2'd2;
    for (int i = 0; i < 16; i++) begin
      in_data_i = 8'(i);
      #1;
      chk($sformatf("tp_rdy%0d", i), 32'(in_ready_o), 32'h1);
      tick();
      chk($sformatf("tp_valid%0d", i), 32'(out_valid_o), 32'b0100);
      chk($sformatf("tp_data%0d", i), 32'(out2_data_o), 32'(i));
    end
    in_valid_i = 1'b0;
    tick();
    chk("tp_drained", 32'(out_valid_o), 32'h0);
    chk("tp_cnt", 32'(cnt_o), 32'd25);

    // Counter wrap
    in_valid_i = 1'b1;
    sel_i      = 2'd0;
    in_data_i  = 8'h5A;
    repeat (65535 - 25) tick();
    chk("wrap_max", 32'(cnt_o), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(cnt_o), 32'h0);
    in_valid_i = 1'b0;
    tick();

    // Reset mid-stream with outputs 1 and 3 stalled
    out_ready_i = 4'b0000;
    in_valid_i  = 1'b1;
    sel_i = 2'd1; in_data_i = 8'h77;
    tick();
    sel_i = 2'd3; in_data_i = 8'h88;
    tick();
    chk("mid_valid", 32'(out_valid_o), 32'b1010);
    chk("mid_data1", 32'(out1_data_o), 32'h77);
    chk("mid_data3", 32'(out3_data_o), 32'h88);
    chk("mid_cnt", 32'(cnt_o), 32'd2);
    in_valid_i = 1'b0;
    rstn_i     = 1'b0;
    tick();
    rstn_i      = 1'b1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'h0);
    chk("mid_rst_cnt", 32'(cnt_o), 32'h0);
    chk("mid_rst_data1", 32'(out1_data_o), 32'h0);
    chk("mid_rst_data3", 32'(out3_data_o), 32'h0);
    out_ready_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_no_replay%0d", i), 32'(out_valid_o), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
